// File: rtl/alu_ex_if.sv
// Bundles the upstream ID/EX handshake, ALU drive/return and downstream EX/MEM
// handshake of alu_ex_stage. slave = the stage; master = its surroundings.
interface alu_ex_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [DW-1:0] in_rs1;
    logic [DW-1:0] in_rs2;
    logic [DW-1:0] in_imm;
    logic [DW-1:0] in_pc;
    logic [4:0]    in_rd;

    logic [DW-1:0] alu_src1;
    logic [DW-1:0] alu_src2;
    logic [3:0]    alu_op;
    logic          alu_enable;
    logic [DW-1:0] alu_result;
    logic          alu_overflow;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [4:0]    out_rd;
    logic          out_illegal;
    logic          out_trap;
    logic          trap_clear;

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2,
               in_imm, in_pc, in_rd, alu_result, alu_overflow, out_ready,
               trap_clear,
        output in_ready, alu_src1, alu_src2, alu_op, alu_enable, out_valid,
               out_result, out_rd, out_illegal, out_trap
    );

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2,
               in_imm, in_pc, in_rd, alu_result, alu_overflow, out_ready,
               trap_clear,
        input  in_ready, alu_src1, alu_src2, alu_op, alu_enable, out_valid,
               out_result, out_rd, out_illegal, out_trap
    );
endinterface

// File: rtl/alu_ex_stage.sv
// RV32I execute-stage front end: decode -> S1 -> external ALU -> S2 -> MEM.
// Optional overflow trap with sticky stall enabled by defining ALU_OVF_TRAP_EN.
module alu_ex_stage #(
    parameter int DW = 32
) (
    input logic   clk,
    input logic   rst,
    alu_ex_if.slave bus
);
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    alu_op_e       dec_op;
    logic [DW-1:0] dec_src1;
    logic [DW-1:0] dec_src2;
    logic          dec_illegal;
    logic          is_r;
    logic          f7_base;
    logic          f7_alt;

    always_comb begin
        dec_op      = ALU_ADD;
        dec_src1    = bus.in_rs1;
        dec_src2    = bus.in_rs2;
        dec_illegal = 1'b0;
        is_r        = (bus.in_opcode == OPC_R);
        f7_base     = (bus.in_funct7 == 7'b0000000);
        f7_alt      = (bus.in_funct7 == F7_ALT);
        case (bus.in_opcode)
            OPC_R, OPC_I: begin
                if (!is_r) dec_src2 = bus.in_imm;
                // I-type funct7 is immediate bits except on the shift encodings
                case (bus.in_funct3)
                    3'b000: begin
                        if (is_r) begin
                            if (f7_alt) dec_op = ALU_SUB;
                            dec_illegal = !(f7_base || f7_alt);
                        end
                    end
                    3'b001: begin
                        dec_op      = ALU_SLL;
                        dec_illegal = !f7_base;
                    end
                    3'b010: begin
                        dec_op      = ALU_SLT;
                        dec_illegal = is_r && !f7_base;
                    end
                    3'b011: begin
                        dec_op      = ALU_SLTU;
                        dec_illegal = is_r && !f7_base;
                    end
                    3'b100: begin
                        dec_op      = ALU_XOR;
                        dec_illegal = is_r && !f7_base;
                    end
                    3'b101: begin
                        dec_op      = f7_alt ? ALU_SRA : ALU_SRL;
                        dec_illegal = !(f7_base || f7_alt);
                    end
                    3'b110: begin
                        dec_op      = ALU_OR;
                        dec_illegal = is_r && !f7_base;
                    end
                    default: begin
                        dec_op      = ALU_AND;
                        dec_illegal = is_r && !f7_base;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_src1 = '0;
                dec_src2 = bus.in_imm;
            end
            OPC_AUIPC: begin
                dec_src1 = bus.in_pc;
                dec_src2 = bus.in_imm;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic          s1_valid;
    alu_op_e       s1_op;
    logic [DW-1:0] s1_src1;
    logic [DW-1:0] s1_src2;
    logic [4:0]    s1_rd;
    logic          s1_illegal;

    logic          out_valid;
    logic [DW-1:0] out_result;
    logic [4:0]    out_rd;
    logic          out_illegal;
    logic          out_trap;

    logic          trap_pending;
    logic          s2_trap;
    logic          s1_live;
    logic          accept;
    logic          s2_load;

    assign s1_live = s1_valid && !s1_illegal;
    assign s2_load = s1_valid && (!out_valid || bus.out_ready);
    assign accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready   = (!s1_valid || s2_load) && !trap_pending;
    assign bus.alu_enable = s1_live;
    assign bus.alu_op     = s1_live ? s1_op : ALU_ADD;
    assign bus.alu_src1   = s1_live ? s1_src1 : '0;
    assign bus.alu_src2   = s1_live ? s1_src2 : '0;

`ifdef ALU_OVF_TRAP_EN
    assign s2_trap = s1_live && bus.alu_overflow &&
                     ((s1_op == ALU_ADD) || (s1_op == ALU_SUB));

    // Set wins over a coincident clear so a fresh trap is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_pending <= 1'b0;
        end else if (s2_load && s2_trap) begin
            trap_pending <= 1'b1;
        end else if (bus.trap_clear) begin
            trap_pending <= 1'b0;
        end
    end
`else
    logic unused_trap_inputs;
    assign unused_trap_inputs = bus.trap_clear | bus.alu_overflow;
    assign s2_trap      = 1'b0;
    assign trap_pending = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= ALU_ADD;
            s1_src1    <= '0;
            s1_src2    <= '0;
            s1_rd      <= '0;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_op      <= dec_op;
            s1_src1    <= dec_src1;
            s1_src2    <= dec_src2;
            s1_rd      <= bus.in_rd;
            s1_illegal <= dec_illegal;
        end else if (s2_load) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
            out_trap    <= 1'b0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            out_result  <= s1_illegal ? '0 : bus.alu_result;
            out_rd      <= s1_rd;
            out_illegal <= s1_illegal;
            out_trap    <= s2_trap;
        end else if (bus.out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_result  = out_result;
    assign bus.out_rd      = out_rd;
    assign bus.out_illegal = out_illegal;
    assign bus.out_trap    = out_trap;
endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage front end that drives the shared ALU from decoded RV32I integer instructions. Accepts one instruction per cycle over a valid/ready handshake, decodes opcode/funct3/funct7 into the 4-bit ALU op code (`ADD … `AND from defines.sv), selects operands, registers the ALU result and overflow flag, and presents them to the MEM stage over a second valid/ready handshake. Sits between the ID/EX pipeline register and the EX/MEM register of the CPU.

## Interface
Parameters:
- DW, 32, datapath width; equals `data_size.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_opcode  in  7  instr[6:0].
- in_funct3  in  3  instr[14:12].
- in_funct7  in  7  instr[31:25].
- in_rs1  in  DW  rs1 data.
- in_rs2  in  DW  rs2 data.
- in_imm  in  DW  sign-extended immediate (U-type already shifted).
- in_pc  in  DW  instruction PC.
- in_rd  in  5  destination register.
- alu_src1 / alu_src2  out  DW  ALU operands.
- alu_op  out  4  ALU op code.
- alu_enable  out  1  ALU enable.
- alu_result  in  DW  ALU result.
- alu_overflow  in  1  ALU overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  DW  registered result.
- out_rd  out  5  destination register.
- out_illegal  out  1  instruction not decodable.
- out_trap  out  1  overflow trap (see Configuration).
- trap_clear  in  1  clears pending trap.

## Operation
- Two registers: S1 (decoded op, operands, rd, illegal) and S2 (result, rd, illegal, trap). ALU is combinational between S1 and S2.
- Decode at accept:
  - 0110011 R: funct3 000→ADD/SUB (funct7 0100000=SUB), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (funct7 0100000=SRA), 110 OR, 111 AND; src1=rs1, src2=rs2. funct7 other than 0000000, or 0100000 with funct3∉{000,101}: illegal.
  - 0010011 I: same mapping, src2=imm; funct3 000 always ADD; shifts use funct7 check as above (0100000 only for 101).
  - 0110111 LUI: ADD, src1=0, src2=imm.
  - 0010111 AUIPC: ADD, src1=pc, src2=imm.
  - Any other opcode: illegal.
- Illegal in S1: alu_enable=0, S2 result=0, out_illegal=1.
- alu_enable=1 only when S1 valid and legal; otherwise alu_op=`ADD, operands 0.
- Overflow is meaningful only for ADD/SUB ops; ignored for all others.

## Timing
- Reset: in_ready=1 after release; out_valid, out_result, out_rd, out_illegal, out_trap, alu_* all 0; S1/S2 invalid. Reset mid-flight drops both entries.
- Latency: accept at edge N → out_valid at edge N+1 (result visible cycle after S1 load).
- Throughput 1/cycle with out_ready held high.
- S2 loads when S1 valid and (!out_valid || out_ready). S1 loads when in_valid && in_ready.
- in_ready = !S1_valid || S2 loading (combinational), and 0 while trap pending.
- out_valid && !out_ready: S2 holds, all out_* stable; S1 holds; in_ready=0 if S1 full.
- Simultaneous S2 drain and S1 refill in the same cycle: both occur, no bubble.

## Configuration
- ALU_OVF_TRAP_EN defined: ADD/SUB with alu_overflow=1 sets out_trap in S2 and a sticky trap_pending; while pending, in_ready=0 (S1/S2 still drain). trap_clear pulse clears pending; trap_clear and new trap same cycle → stays pending.
- Undefined: out_trap tied 0, trap_clear ignored, overflow never stalls; wrapped result still delivered.

## Test plan
- Reset release: all outputs 0, in_ready=1; ADD rs1=5 rs2=7 → out_result=12, out_rd preserved, out_valid one cycle after accept.
- Back-to-back SUB, SRA (rs1=0x80000000, rs2=4 → 0xF8000000), SLTU (1,0xFFFFFFFF → 1), LUI imm=0x12345000 → results in order, one per cycle, no bubbles.
- out_ready low 3 cycles with two instructions in flight → out_result stable, in_ready=0, both delivered in order after release.
- Illegal opcode 0000011 and R-type funct7=0100000 funct3=100 → out_illegal=1, out_result=0, alu_enable=0 while in S1.
- ALU_OVF_TRAP_EN: ADD 0x7FFFFFFF+1 → out_result=0x80000000, out_trap=1, in_ready=0 until trap_clear; without macro, out_trap=0 and no stall.
- Assert rst while both stages full → out_valid drops immediately, no stale result after release.
